// File: rtl/sram_port_arbiter.sv
// Two-master arbiter for the shared data-SRAM port.
// m0 = instruction fetch, m1 = load/store path. One access per cycle is
// granted combinationally; read returns are routed back to their issuer
// through a fixed-depth tag pipeline that matches the SRAM read latency.
module sram_port_arbiter #(
  parameter int READ_LATENCY  = 1,  // 1..4
  parameter int PRIORITY_MODE = 0,  // 0 round-robin, 1 fixed m1 with m0 guard
  parameter int MAX_WAIT      = 7   // 1..15, fixed mode only
) (
  input  logic        clk,
  input  logic        reset,       // synchronous, active low
  input  logic        m0_req,
  input  logic [3:0]  m0_wen,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [3:0]  m1_wen,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  logic                    r_last_grant;  // 0 = m0, 1 = m1
  logic [3:0]              r_wait_cnt;
  logic [READ_LATENCY-1:0] r_vld_pipe;
  logic [READ_LATENCY-1:0] r_own_pipe;
  logic                    r_m0_rvalid, r_m1_rvalid;
  logic [31:0]             r_m0_rdata, r_m1_rdata;

  logic w_gnt0, w_gnt1;
  logic w_rd_issue;
  logic w_ret_vld, w_ret_own;

  // Grant decision; everything is suppressed while reset is held low
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (reset) begin
      if (m0_req && m1_req) begin
        if (PRIORITY_MODE == 0) begin
          w_gnt0 = r_last_grant;
          w_gnt1 = ~r_last_grant;
        end else begin
          w_gnt0 = (r_wait_cnt == LP_MAX_WAIT);
          w_gnt1 = ~w_gnt0;
        end
      end else begin
        w_gnt0 = m0_req;
        w_gnt1 = m1_req;
      end
    end
  end

  // SRAM port mux; idle port is driven to all zeros
  always_comb begin
    sram_en    = w_gnt0 | w_gnt1;
    sram_wen   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (w_gnt0) begin
      sram_wen   = m0_wen;
      sram_addr  = m0_addr;
      sram_wdata = m0_wdata;
    end else if (w_gnt1) begin
      sram_wen   = m1_wen;
      sram_addr  = m1_addr;
      sram_wdata = m1_wdata;
    end
  end

  assign m0_gnt     = w_gnt0;
  assign m1_gnt     = w_gnt1;
  assign w_rd_issue = sram_en && (sram_wen == 4'b0000);
  assign w_ret_vld  = r_vld_pipe[READ_LATENCY-1];
  assign w_ret_own  = r_own_pipe[READ_LATENCY-1];

  // Remember the last winner so round-robin alternates under contention
  always_ff @(posedge clk) begin
    if (!reset)      r_last_grant <= 1'b1;
    else if (w_gnt0) r_last_grant <= 1'b0;
    else if (w_gnt1) r_last_grant <= 1'b1;
  end

  // Count consecutive denied m0 cycles (fixed mode only), saturating
  always_ff @(posedge clk) begin
    if (!reset || PRIORITY_MODE == 0)
      r_wait_cnt <= '0;
    else if (m0_req && !w_gnt0)
      r_wait_cnt <= (r_wait_cnt == LP_MAX_WAIT) ? r_wait_cnt : r_wait_cnt + 4'd1;
    else
      r_wait_cnt <= '0;
  end

  // Read tag pipeline: one stage per cycle of SRAM latency, never stalls
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_vld_pipe <= '0;
      r_own_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= w_rd_issue;
      r_own_pipe[0] <= w_gnt1;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_own_pipe[i] <= r_own_pipe[i-1];
      end
    end
  end

  // Steer returning SRAM data to the owner of the tag; rdata holds between returns
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
    end else begin
      r_m0_rvalid <= w_ret_vld && !w_ret_own;
      r_m1_rvalid <= w_ret_vld &&  w_ret_own;
      if (w_ret_vld && !w_ret_own) r_m0_rdata <= sram_rdata;
      if (w_ret_vld &&  w_ret_own) r_m1_rdata <= sram_rdata;
    end
  end

  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: four configurations share one stimulus stream;
// a transaction-level model predicts grants and read returns per config.
module tb_sram_port_arbiter;

  localparam int NK = 4;
  localparam int LATS [NK] = '{1, 3, 2, 4};
  localparam int PMS  [NK] = '{0, 1, 0, 1};
  localparam int MWS  [NK] = '{7, 3, 7, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        r0, r1;
  logic [3:0]  wen0, wen1;
  logic [31:0] addr0, addr1, wd0, wd1;

  logic        m0_gnt [NK], m1_gnt [NK], m0_rvalid [NK], m1_rvalid [NK];
  logic [31:0] m0_rdata [NK], m1_rdata [NK];
  logic        sram_en [NK];
  logic [3:0]  sram_wen [NK];
  logic [31:0] sram_addr [NK], sram_wdata [NK], sram_rdata [NK];

  for (genvar k = 0; k < NK; k++) begin : g_dut
    sram_port_arbiter #(
      .READ_LATENCY(LATS[k]), .PRIORITY_MODE(PMS[k]), .MAX_WAIT(MWS[k])
    ) u_dut (
      .clk(clk), .reset(rst_n),
      .m0_req(r0), .m0_wen(wen0), .m0_addr(addr0), .m0_wdata(wd0),
      .m0_gnt(m0_gnt[k]), .m0_rvalid(m0_rvalid[k]), .m0_rdata(m0_rdata[k]),
      .m1_req(r1), .m1_wen(wen1), .m1_addr(addr1), .m1_wdata(wd1),
      .m1_gnt(m1_gnt[k]), .m1_rvalid(m1_rvalid[k]), .m1_rdata(m1_rdata[k]),
      .sram_en(sram_en[k]), .sram_wen(sram_wen[k]), .sram_addr(sram_addr[k]),
      .sram_wdata(sram_wdata[k]), .sram_rdata(sram_rdata[k])
    );
  end

  // Outstanding read: which config, which master, edge at which data returns
  typedef struct {
    int          k;
    bit          own;
    int          due;
    logic [31:0] d;
  } ret_t;

  ret_t        q[$];
  bit          last [NK];    // 1 = m1 won last
  int          wcnt [NK];
  logic [31:0] erd  [NK][2];
  int          cyc = 0;
  int          nchk = 0, npass = 0, nfail = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h5A5A0F0F);
  endfunction

  task automatic chk(input string tag, input int k, input logic [127:0] obs,
                     input logic [127:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s dut%0d obs=%0h exp=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic drive(input logic a_r0, input logic [3:0] a_w0, input logic [31:0] a_a0,
                       input logic [31:0] a_d0, input logic a_r1, input logic [3:0] a_w1,
                       input logic [31:0] a_a1, input logic [31:0] a_d1);
    r0 = a_r0; wen0 = a_w0; addr0 = a_a0; wd0 = a_d0;
    r1 = a_r1; wen1 = a_w1; addr1 = a_a1; wd1 = a_d1;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // One clock cycle: SRAM responder, combinational checks, edge, return checks
  task automatic step();
    ret_t        nq[$];
    logic [1:0]  ev [NK];
    int          g;
    logic [3:0]  ew;
    logic [31:0] ea, ed;
    for (int k = 0; k < NK; k++) begin
      sram_rdata[k] = $urandom;
      foreach (q[i]) if (q[i].k == k && q[i].due == cyc + 1) sram_rdata[k] = q[i].d;
    end
    #1;
    for (int k = 0; k < NK; k++) begin
      g = -1;
      if (rst_n) begin
        if (r0 && r1) begin
          if (PMS[k] == 1) g = (wcnt[k] == MWS[k]) ? 0 : 1;
          else             g = last[k] ? 0 : 1;
        end else if (r0) g = 0;
        else if (r1)     g = 1;
      end
      ew = (g == 0) ? wen0  : (g == 1) ? wen1  : 4'h0;
      ea = (g == 0) ? addr0 : (g == 1) ? addr1 : 32'h0;
      ed = (g == 0) ? wd0   : (g == 1) ? wd1   : 32'h0;
      chk("port", k,
          {m0_gnt[k], m1_gnt[k], sram_en[k], sram_wen[k], sram_addr[k], sram_wdata[k]},
          {g == 0, g == 1, g >= 0, ew, ea, ed});
      if (!rst_n) begin
        last[k] = 1'b1;
        wcnt[k] = 0;
      end else begin
        if (g >= 0) last[k] = (g == 1);
        if (PMS[k] == 1 && r0 && g != 0) wcnt[k] = (wcnt[k] < MWS[k]) ? wcnt[k] + 1 : MWS[k];
        else wcnt[k] = 0;
      end
      if (g >= 0 && ew == 4'h0)
        q.push_back('{k: k, own: (g == 1), due: cyc + 1 + LATS[k], d: memf(ea)});
    end
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      q.delete();
      for (int k = 0; k < NK; k++) begin erd[k][0] = '0; erd[k][1] = '0; end
    end
    #1;
    for (int k = 0; k < NK; k++) ev[k] = 2'b00;
    foreach (q[i]) begin
      if (q[i].due == cyc) begin
        ev[q[i].k][q[i].own] = 1'b1;
        erd[q[i].k][q[i].own] = q[i].d;
      end else nq.push_back(q[i]);
    end
    q = nq;
    for (int k = 0; k < NK; k++) begin
      chk("rvalid", k, {m1_rvalid[k], m0_rvalid[k]}, ev[k]);
      chk("m0_rdata", k, m0_rdata[k], erd[k][0]);
      chk("m1_rdata", k, m1_rdata[k], erd[k][1]);
    end
  endtask

  initial begin
    for (int k = 0; k < NK; k++) begin
      last[k] = 1'b1; wcnt[k] = 0; erd[k][0] = '0; erd[k][1] = '0;
    end
    // reset
    rst_n = 1'b0;
    idle();
    step(); step();
    rst_n = 1'b1;

    // single m0 read of 0x100; returns two edges after the grant on the L=1 config
    drive(1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    idle();
    step();
    chk("single_rd", 0, {m0_rvalid[0], m1_rvalid[0], m0_rdata[0]}, {2'b10, 32'hDEADBEEF});
    repeat (4) step();

    // round-robin conflict straight out of reset
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'h0, 32'h200 + 4 * i, 32'h0, 1'b1, 4'h0, 32'h300 + 4 * i, 32'h0);
      #1;
      chk("rr_gnt", 0, {m0_gnt[0], m1_gnt[0]}, (i % 2 == 0) ? 2'b10 : 2'b01);
      step();
    end
    idle();
    repeat (6) step();

    // fixed priority, MAX_WAIT=3: m1 x3, m0, m1 x3, m0
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 4'h0, 32'h400 + 4 * i, 32'h0, 1'b1, 4'h0, 32'h500 + 4 * i, 32'h0);
      #1;
      chk("fp_gnt", 1, {m0_gnt[1], m1_gnt[1]}, (i % 4 == 3) ? 2'b10 : 2'b01);
      step();
    end
    idle();
    repeat (6) step();

    // m1 byte write: no return on either port
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'b0100, 32'h600, 32'h00AB0000);
    step();
    idle();
    repeat (6) step();

    // latency sweep: m0 read, m1 read, m0 write back to back
    drive(1'b1, 4'h0, 32'h700, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h704, 32'h0);
    step();
    drive(1'b1, 4'hF, 32'h708, 32'h12345678, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    idle();
    repeat (7) step();

    // reset while an m1 read is in flight, then a conflict after release
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h800, 32'h0);
    step();
    idle();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    drive(1'b1, 4'h0, 32'h900, 32'h0, 1'b1, 4'h0, 32'h904, 32'h0);
    #1;
    chk("post_rst_gnt", 2, {m0_gnt[2], m1_gnt[2]}, 2'b10);
    step();
    idle();
    repeat (6) step();

    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      drive($urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom),
            32'($urandom_range(0, 63)) << 2, $urandom,
            $urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom),
            32'($urandom_range(0, 63)) << 2, $urandom);
      step();
    end
    rst_n = 1'b1;
    idle();
    repeat (6) step();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
